prog_clk_div: RTL and testbench
===============================

PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 27: divisor and counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 100_000_000: per-channel divisor loaded at reset.
REQ-004 SHALL have port clk_in, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, NCH: per-channel run enable.
REQ-007 SHALL have port cfg_valid, input, 1: divisor write request.
REQ-008 SHALL have port cfg_ch, input, max(1,$clog2(NCH)): target channel of the write.
REQ-009 SHALL have port cfg_div, input, WIDTH: new divisor value.
REQ-010 SHALL have port cfg_ready, output, 1: write can be accepted this cycle.
REQ-011 SHALL have port sync, input, 1: phase-align strobe; present only with PROG_CLK_DIV_SYNC_EN.
REQ-012 SHALL have port clk_out, output, NCH: divided clock-enable waveforms, registered.
REQ-013 SHALL have port tick, output, NCH: one-cycle pulse at each period start, registered.

Function
REQ-014 Per channel: counter cnt counts 0..D-1, then wraps to 0; D is the active divisor.
REQ-015 clk_out[i] SHALL be 1 while cnt < H and 0 otherwise, where H = D - floor(D/2), so odd D gets the extra high cycle.
REQ-016 tick[i] SHALL be 1 exactly in cycles where cnt == 0 with the channel running.
REQ-017 D == 1: clk_out[i] constant 1 and tick[i] 1 every cycle while enabled.
REQ-018 D == 0: channel stopped; cnt held 0; clk_out[i] = 0; tick[i] = 0 regardless of en.
REQ-019 en[i] low: cnt held 0, clk_out[i] = 0, tick[i] = 0; en rising sampled at cycle t gives clk_out[i] = 1 and tick[i] = 1 in cycle t+1.
REQ-020 Write is accepted when cfg_valid && cfg_ready; cfg_ch >= NCH is accepted and discarded.
REQ-021 Accepted divisor goes to a per-channel pending register; pend[i] is set.
REQ-022 Pending divisor becomes active at the next wrap (cnt == D-1 -> 0), or on the next cycle if the channel is disabled or has D == 0; pend[i] then clears.
REQ-023 cfg_ready SHALL equal !pend[cfg_ch] (combinational on cfg_ch), so no write overwrites an unapplied one.
REQ-024 Write and wrap in the same cycle on the same channel: the old pending value is applied and the new value becomes pending.
REQ-025 The counter SHALL never exceed D-1; wrap compare SHALL be exact at WIDTH bits with no overflow for D = 2^WIDTH-1.

Reset
REQ-026 rst SHALL set all cnt to 0, active divisors to DEFAULT_DIV, pend to 0, clk_out to 0, tick to 0; cfg_ready reads 1 in the first cycle after reset.
REQ-027 rst mid-period SHALL abort the period; the first tick follows one cycle after rst deasserts with en high.

Configuration
REQ-028 With PROG_CLK_DIV_SYNC_EN defined: sync high forces every enabled channel to apply any pending divisor and restart at cnt 0 next cycle, with tick and clk_out high on all of them together; sync has lower priority than rst.
REQ-029 Without PROG_CLK_DIV_SYNC_EN: no sync port, and channels free-run independently.

Structure
REQ-030 Package prog_clk_div_pkg SHALL hold the default WIDTH, DEFAULT_DIV and the channel-index width function.
REQ-031 Per-channel counter, shadow register and output logic SHALL be sub-module clk_div_chan, instantiated NCH times by generate.

Verification
REQ-032 D=4 on ch0, en=1: clk_out 1,1,0,0 repeating; tick every 4th cycle coincident with clk_out rise.
REQ-033 D=5: clk_out high 3 cycles, low 2; D=1: clk_out constant 1 and tick every cycle; D=0: both outputs stay 0.
REQ-034 Write D=6 at cnt=1 of a D=4 period: cfg_ready for ch0 drops; the period completes at 4; the next period is 6; cfg_ready returns to 1.
REQ-035 en drops mid-period then rises at cycle t: outputs 0 while low, and tick=1 at t+1.
REQ-036 Channels at D=3 and D=7 with SYNC_EN: pulse sync at an arbitrary cycle; both tick in the next cycle, then ticks repeat at 3 and 7.
REQ-037 Assert rst at cnt=50 with D=100: all outputs are 0 the cycle after, D reverts to DEFAULT_DIV, and pending writes are lost.

Source files
------------

// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
package prog_clk_div_pkg;

   localparam int          DEF_WIDTH = 27;
   localparam int unsigned DEF_DIV   = 100_000_000;

   // Channel-select width; a single channel still needs a 1-bit select.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Divisor-write bus: one write per cycle when cfg_valid && cfg_ready.
// cfg_ready is combinational on cfg_ch and never depends on cfg_valid.
interface prog_clk_div_if
   import prog_clk_div_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int WIDTH = DEF_WIDTH
);
   localparam int CW = ch_width(NCH);

   logic             cfg_valid;
   logic [CW-1:0]    cfg_ch;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_ready;

   modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor pair and registered outputs.
module clk_div_chan
   import prog_clk_div_pkg::*;
#(
   parameter int          WIDTH       = DEF_WIDTH,
   parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wr_div_i,
   output logic             pend_o,
   output logic             clk_out_o,
   output logic             tick_o
);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pdiv_q, pdiv_d;
   logic             pend_q, pend_d;
   logic             run_q, run_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             wrap;
   logic             apply;

   always_comb begin
      // run_q implies div_q != 0, so div_q - 1 cannot underflow when it matters.
      wrap   = run_q && (cnt_q == div_q - ONE);
      apply  = !en_i || (div_q == '0) || !run_q || wrap || sync_i;
      div_d  = (apply && pend_q) ? pdiv_q : div_q;
      pend_d = wr_i ? 1'b1 : (apply ? 1'b0 : pend_q);
      pdiv_d = wr_i ? wr_div_i : pdiv_q;
      run_d  = en_i && (div_d != '0);
      if (!run_d || !run_q || wrap || sync_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
      tick_d    = run_d && (cnt_d == '0);
      clk_out_d = run_d && (cnt_d < (div_d - (div_d >> 1)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         div_q     <= DIV_RST;
         pdiv_q    <= '0;
         pend_q    <= 1'b0;
         run_q     <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         pdiv_q    <= pdiv_d;
         pend_q    <= pend_d;
         run_q     <= run_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign pend_o    = pend_q;
   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/prog_clk_div.sv
// NCH-channel programmable clock-enable divider with shadowed divisor writes.
// Optional PROG_CLK_DIV_SYNC_EN adds a sync strobe that restarts all enabled channels together.
module prog_clk_div
   import prog_clk_div_pkg::*;
#(
   parameter int          NCH         = 4,
   parameter int          WIDTH       = DEF_WIDTH,
   parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
   input  logic           clk_in,
   input  logic           rst,
   input  logic [NCH-1:0] en,
   prog_clk_div_if.slave  cfg,
`ifdef PROG_CLK_DIV_SYNC_EN
   input  logic           sync,
`endif
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] tick
);
   localparam int CW = ch_width(NCH);

   logic [NCH-1:0]      pend;
   logic [(1<<CW)-1:0]  pend_ext;
   logic                sync_w;

`ifdef PROG_CLK_DIV_SYNC_EN
   assign sync_w = sync;
`else
   assign sync_w = 1'b0;
`endif

   // Unused channel indices read as not-pending, so out-of-range writes are taken and dropped.
   always_comb begin
      pend_ext          = '0;
      pend_ext[NCH-1:0] = pend;
   end

   assign cfg.cfg_ready = ~pend_ext[cfg.cfg_ch];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic wr;
      assign wr = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CW'(i));

      clk_div_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_i     (clk_in),
         .rst_i     (rst),
         .en_i      (en[i]),
         .sync_i    (sync_w),
         .wr_i      (wr),
         .wr_div_i  (cfg.cfg_div),
         .pend_o    (pend[i]),
         .clk_out_o (clk_out[i]),
         .tick_o    (tick[i])
      );
   end

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div; the sync scenario is built when PROG_CLK_DIV_SYNC_EN is defined.
module tb_prog_clk_div;
   localparam int NCH   = 3;
   localparam int WIDTH = 8;
   localparam int DDEF  = 12;

   logic             clk;
   logic             rst;
   logic [NCH-1:0]   en;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;
`ifdef PROG_CLK_DIV_SYNC_EN
   logic             sync;
`endif

   prog_clk_div_if #(.NCH(NCH), .WIDTH(WIDTH)) cfg_if ();

   prog_clk_div #(
      .NCH         (NCH),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DDEF)
   ) dut (
      .clk_in  (clk),
      .rst     (rst),
      .en      (en),
      .cfg     (cfg_if),
`ifdef PROG_CLK_DIV_SYNC_EN
      .sync    (sync),
`endif
      .clk_out (clk_out),
      .tick    (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   logic [2*NCH-1:0] exp_q[$];
   int               ed[NCH];
   int               ek[NCH];
   bit               eon[NCH];

   // Expected {clk_out, tick} of one channel k cycles into its run at divisor d.
   function automatic logic [1:0] chan_exp(input int d, input int k);
      int m;
      if (d == 0) return 2'b00;
      m = k % d;
      return {(m < (d - d / 2)), (m == 0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NCH; i++) begin
         eon[i] = 1'b0;
         ek[i]  = 0;
      end
   endtask

   task automatic push_cycle();
      logic [NCH-1:0] c, t;
      logic [1:0]     p;
      for (int i = 0; i < NCH; i++) begin
         p    = eon[i] ? chan_exp(ed[i], ek[i]) : 2'b00;
         c[i] = p[1];
         t[i] = p[0];
         if (eon[i]) ek[i]++;
      end
      exp_q.push_back({c, t});
   endtask

   // Divisor write with all channels idle: accepted on one edge, applied on the next.
   task automatic do_write(input int ch, input int d);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'(ch);
      cfg_if.cfg_div   = WIDTH'(d);
      step();
      cfg_if.cfg_valid = 1'b0;
      step();
      ed[ch] = d;
   endtask

   task automatic stop_all();
      en = '0;
      clear_exp();
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = '0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_div   = '0;
      repeat (3) step();
      tests++;
      if (clk_out !== 3'b000) begin failed++; $display("FAIL reset_clk_out got=%b exp=000", clk_out); end
      tests++;
      if (tick !== 3'b000) begin failed++; $display("FAIL reset_tick got=%b exp=000", tick); end
      rst = 1'b0;
      tests++;
      if (cfg_if.cfg_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
      for (int i = 0; i < NCH; i++) ed[i] = DDEF;
      clear_exp();
   endtask

   task automatic test_default_div();
      logic [2*NCH-1:0] exp_v, got_v;
      en = 3'b001;
      eon[0] = 1'b1;
      for (int c = 0; c < 2 * DDEF + 2; c++) begin
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL default_div c=%0d got=%b exp=%b", c, got_v, exp_v); end
      end
      stop_all();
   endtask

   task automatic test_div_values();
      logic [2*NCH-1:0] exp_v, got_v;
      do_write(0, 4);
      do_write(1, 5);
      do_write(2, 1);
      en = 3'b111;
      for (int i = 0; i < NCH; i++) eon[i] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL div_4_5_1 c=%0d got=%b exp=%b", c, got_v, exp_v); end
      end
      stop_all();
      do_write(1, 0);
      en = 3'b010;
      eon[1] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL div_zero c=%0d got=%b exp=%b", c, got_v, exp_v); end
      end
      stop_all();
   endtask

   task automatic test_pending();
      logic [2*NCH-1:0] exp_v, got_v;
      logic             exp_r;
      do_write(0, 4);
      cfg_if.cfg_ch = 2'd0;
      en = 3'b001;
      eon[0] = 1'b1;
      for (int c = 0; c < 22; c++) begin
         if (c == 4)  begin ed[0] = 6; ek[0] = 0; end
         if (c == 16) begin ed[0] = 3; ek[0] = 0; end
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL pending_pattern c=%0d got=%b exp=%b", c, got_v, exp_v); end
         exp_r = !((c >= 2 && c <= 3) || (c >= 10 && c <= 15));
         tests++;
         if (cfg_if.cfg_ready !== exp_r) begin failed++; $display("FAIL pending_ready c=%0d got=%b exp=%b", c, cfg_if.cfg_ready, exp_r); end
         cfg_if.cfg_valid = 1'b0;
         if (c == 1) begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd6; end
         if (c == 9) begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd3; end
      end
      cfg_if.cfg_valid = 1'b0;
      stop_all();
   endtask

   task automatic test_out_of_range();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'd3;
      cfg_if.cfg_div   = 8'd7;
      #1;
      tests++;
      if (cfg_if.cfg_ready !== 1'b1) begin failed++; $display("FAIL oor_ready got=%b exp=1", cfg_if.cfg_ready); end
      step();
      cfg_if.cfg_valid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         cfg_if.cfg_ch = 2'(i);
         #1;
         tests++;
         if (cfg_if.cfg_ready !== 1'b1) begin failed++; $display("FAIL oor_no_pend ch=%0d got=%b exp=1", i, cfg_if.cfg_ready); end
      end
      cfg_if.cfg_ch = 2'd0;
      step();
   endtask

   task automatic test_en_toggle();
      logic [2*NCH-1:0] exp_v, got_v;
      do_write(0, 4);
      en = 3'b001;
      eon[0] = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c == 6)  eon[0] = 1'b0;
         if (c == 10) begin eon[0] = 1'b1; ek[0] = 0; end
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL en_toggle c=%0d got=%b exp=%b", c, got_v, exp_v); end
         if (c == 5) en = 3'b000;
         if (c == 9) en = 3'b001;
      end
      stop_all();
   endtask

   task automatic test_max_div();
      logic [2*NCH-1:0] exp_v, got_v;
      do_write(2, 255);
      en = 3'b100;
      eon[2] = 1'b1;
      for (int c = 0; c < 515; c++) begin
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL max_div c=%0d got=%b exp=%b", c, got_v, exp_v); end
      end
      stop_all();
   endtask

`ifdef PROG_CLK_DIV_SYNC_EN
   task automatic test_sync();
      logic [2*NCH-1:0] exp_v, got_v;
      int               r;
      do_write(0, 3);
      do_write(1, 7);
      r = int'($urandom_range(3, 12));
      en = 3'b011;
      eon[0] = 1'b1;
      eon[1] = 1'b1;
      for (int c = 0; c < r + 24; c++) begin
         if (c == r + 1) begin ek[0] = 0; ek[1] = 0; end
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL sync c=%0d r=%0d got=%b exp=%b", c, r, got_v, exp_v); end
         sync = (c == r);
      end
      sync = 1'b0;
      stop_all();
   endtask
`endif

   task automatic test_reset_mid();
      logic [2*NCH-1:0] exp_v, got_v;
      do_write(0, 100);
      cfg_if.cfg_ch = 2'd0;
      en = 3'b001;
      eon[0] = 1'b1;
      for (int c = 0; c <= 50; c++) begin
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL rst_mid_pre c=%0d got=%b exp=%b", c, got_v, exp_v); end
         cfg_if.cfg_valid = (c == 48);
         cfg_if.cfg_div   = 8'd20;
      end
      tests++;
      if (cfg_if.cfg_ready !== 1'b0) begin failed++; $display("FAIL rst_mid_pend_ready got=%b exp=0", cfg_if.cfg_ready); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if ({clk_out, tick} !== 6'b0) begin failed++; $display("FAIL rst_mid_outputs got=%b exp=000000", {clk_out, tick}); end
      tests++;
      if (cfg_if.cfg_ready !== 1'b1) begin failed++; $display("FAIL rst_mid_ready got=%b exp=1", cfg_if.cfg_ready); end
      clear_exp();
      for (int i = 0; i < NCH; i++) ed[i] = DDEF;
      eon[0] = 1'b1;
      for (int c = 0; c < 2 * DDEF + 2; c++) begin
         push_cycle();
         step();
         exp_v = exp_q.pop_front();
         got_v = {clk_out, tick};
         tests++;
         if (got_v !== exp_v) begin failed++; $display("FAIL rst_mid_post c=%0d got=%b exp=%b", c, got_v, exp_v); end
      end
      stop_all();
   endtask

   initial begin
`ifdef PROG_CLK_DIV_SYNC_EN
      sync = 1'b0;
`endif
      test_reset();
      test_default_div();
      test_div_values();
      test_pending();
      test_out_of_range();
      test_en_toggle();
      test_max_div();
`ifdef PROG_CLK_DIV_SYNC_EN
      test_sync();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
